// File: rtl/contra_sprite_pkg.sv
// Shared sprite types and enemy geometry for the sprite fetch blocks.
package contra_sprite_pkg;
  typedef logic [9:0] coord_t;
  typedef logic [2:0] pal_idx_t;

  localparam int ENEMY_W      = 24;
  localparam int ENEMY_H      = 32;
  localparam int ENEMY_FRAMES = 3;
  localparam pal_idx_t KEY_INDEX = 3'd0;
endpackage

// File: rtl/sprite_anim_counter.sv
// Animation frame sequencer: advances one frame every FRAME_HOLD ticks while running.
module sprite_anim_counter #(
  parameter int NUM_FRAMES = 3,
  parameter int FRAME_HOLD = 6,
  parameter int FRAME_W    = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_tick,
  input  logic               i_run,
  output logic [FRAME_W-1:0] o_frame
);
  localparam int HOLD_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

  logic [HOLD_W-1:0]  r_hold;
  logic [FRAME_W-1:0] r_frame;

  // Standing pose wins over a coincident tick so the cycle always restarts cleanly.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hold  <= '0;
      r_frame <= '0;
    end else if (!i_run) begin
      r_hold  <= '0;
      r_frame <= '0;
    end else if (i_tick) begin
      if (r_hold == HOLD_W'(FRAME_HOLD - 1)) begin
        r_hold  <= '0;
        r_frame <= (r_frame == FRAME_W'(NUM_FRAMES - 1)) ? '0 : r_frame + 1'b1;
      end else begin
        r_hold <= r_hold + 1'b1;
      end
    end
  end

  assign o_frame = r_frame;
endmodule

// File: rtl/enemy_sprite_fetch.sv
// Enemy sprite fetch: box test + ROM address at stage 0, colour index out 3 cycles later.
module enemy_sprite_fetch
  import contra_sprite_pkg::*;
#(
  parameter int SPRITE_W   = ENEMY_W,
  parameter int SPRITE_H   = ENEMY_H,
  parameter int NUM_FRAMES = ENEMY_FRAMES,
  parameter int FRAME_HOLD = 6,
  parameter int COORD_W    = $bits(coord_t),
  parameter int ADDR_W     = 12
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_tick,
  input  logic               running,
  input  logic               face_left,
  input  logic [COORD_W-1:0] enemy_x,
  input  logic [COORD_W-1:0] enemy_y,
  input  logic [COORD_W-1:0] draw_x,
  input  logic [COORD_W-1:0] draw_y,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [2:0]         rom_q,
  output logic [2:0]         palette_index,
  output logic               opaque,
  output logic [1:0]         frame_num
);
  localparam int STAGES = 2;

  logic [COORD_W-1:0] r_ex, r_ey;
  logic               r_face;
  logic [ADDR_W-1:0]  r_rom_addr;
  logic [STAGES-1:0]  r_vld_pipe;
  pal_idx_t           r_pal;
  logic               r_opq;
  logic [1:0]         w_frame;

  sprite_anim_counter #(
    .NUM_FRAMES (NUM_FRAMES),
    .FRAME_HOLD (FRAME_HOLD),
    .FRAME_W    (2)
  ) u_anim (
    .i_clk   (Clk),
    .i_rst_n (Reset_n),
    .i_tick  (frame_tick),
    .i_run   (running),
    .o_frame (w_frame)
  );

  // Position only moves during vsync so a frame never tears.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_ex   <= '0;
      r_ey   <= '0;
      r_face <= 1'b0;
    end else if (frame_tick) begin
      r_ex   <= enemy_x;
      r_ey   <= enemy_y;
      r_face <= face_left;
    end
  end

  // Bounds computed one bit wider so a box near the right edge doesn't wrap.
  logic [COORD_W:0]   w_dx, w_dy, w_x0, w_y0, w_x1, w_y1;
  logic               w_inside;
  logic [COORD_W-1:0] w_lx, w_ly, w_col;
  logic [ADDR_W-1:0]  w_addr;

  always_comb begin
    w_dx     = {1'b0, draw_x};
    w_dy     = {1'b0, draw_y};
    w_x0     = {1'b0, r_ex};
    w_y0     = {1'b0, r_ey};
    w_x1     = w_x0 + (COORD_W+1)'(SPRITE_W);
    w_y1     = w_y0 + (COORD_W+1)'(SPRITE_H);
    w_inside = (w_dx >= w_x0) && (w_dx < w_x1) && (w_dy >= w_y0) && (w_dy < w_y1);
    w_lx     = draw_x - r_ex;
    w_ly     = draw_y - r_ey;
    w_col    = r_face ? (COORD_W'(SPRITE_W - 1) - w_lx) : w_lx;
    w_addr   = ADDR_W'(w_frame) * ADDR_W'(SPRITE_W * SPRITE_H)
             + ADDR_W'(w_ly) * ADDR_W'(SPRITE_W)
             + ADDR_W'(w_col);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rom_addr <= '0;
      r_vld_pipe <= '0;
      r_pal      <= '0;
      r_opq      <= 1'b0;
    end else begin
      r_rom_addr <= w_inside ? w_addr : '0;
      r_vld_pipe <= {r_vld_pipe[STAGES-2:0], w_inside};
      if (r_vld_pipe[STAGES-1]) begin
        r_pal <= rom_q;
        r_opq <= (rom_q != KEY_INDEX);
      end else begin
        r_pal <= '0;
        r_opq <= 1'b0;
      end
    end
  end

  assign rom_addr      = r_rom_addr;
  assign palette_index = r_pal;
  assign opaque        = r_opq;
  assign frame_num     = w_frame;
endmodule

// File: doc/enemy_sprite_fetch.md
Name: enemy_sprite_fetch

Overview:
Per-pixel sprite fetch stage for the running green enemy. It sits directly upstream of the enemy's 8-entry palette lookup. Each cycle it takes the current draw coordinate and does three things: tests it against the enemy bounding box, selects the animation frame and horizontal mirroring, and drives the sprite ROM address. It then returns the ROM's 3-bit colour index, aligned with an opaque flag, so the palette and the colour mixer can consume them. Index 0 is the green chroma key and counts as transparent.

Parameters:
SPRITE_W, 24, sprite width in pixels
SPRITE_H, 32, sprite height in pixels
NUM_FRAMES, 3, run-cycle frames stored back-to-back in ROM
FRAME_HOLD, 6, frame_tick pulses per animation frame
COORD_W, 10, screen coordinate width
ADDR_W, 12, ROM address width; must satisfy NUM_FRAMES*SPRITE_W*SPRITE_H <= 2^ADDR_W

Ports:
Clk  in  1  pixel clock
Reset_n  in  1  asynchronous, active-low reset
frame_tick  in  1  one-cycle pulse per video frame (vsync)
running  in  1  1 = animate; 0 = standing pose (frame 0)
face_left  in  1  1 = mirror horizontally
enemy_x  in  COORD_W  top-left x of sprite
enemy_y  in  COORD_W  top-left y of sprite
draw_x  in  COORD_W  current pixel x
draw_y  in  COORD_W  current pixel y
rom_addr  out  ADDR_W  sprite ROM address; synchronous ROM with 1-cycle read latency
rom_q  in  3  ROM data, valid the cycle after rom_addr
palette_index  out  3  colour index to the palette
opaque  out  1  pixel is inside the sprite and rom_q != 0
frame_num  out  2  current animation frame

Behaviour:
- Reset (Reset_n=0, asynchronous): every register and output is 0 (rom_addr, palette_index, opaque, frame_num, hold counter, latched position, latched face).
- Position latch: enemy_x, enemy_y and face_left are sampled only on cycles where frame_tick=1. This prevents tearing mid-frame. All hit tests use the latched values.
- Animation counter:
  - running=0: hold_cnt and frame_num are cleared synchronously. This takes priority over a coincident frame_tick.
  - running=1 and frame_tick=1: hold_cnt increments.
  - When hold_cnt==FRAME_HOLD-1, hold_cnt goes to 0 and frame_num advances. frame_num wraps from NUM_FRAMES-1 to 0.
- Hit test, stage 0, combinational:
  - inside = (draw_x >= ex) && (draw_x < ex+SPRITE_W) && (draw_y >= ey) && (draw_y < ey+SPRITE_H).
  - Sums use COORD_W+1 bits, so a box near x=1023 does not wrap.
  - lx = draw_x-ex, ly = draw_y-ey.
  - col = face ? SPRITE_W-1-lx : lx.
- Address: frame_num*SPRITE_W*SPRITE_H + ly*SPRITE_W + col, truncated to ADDR_W. It is registered into rom_addr at the end of cycle N. rom_addr is 0 when not inside.
- Pipeline:
  - inside is delayed 2 stages to align with rom_q.
  - rom_q is valid in cycle N+2.
  - palette_index and opaque are registered at the end of N+2, so the fixed latency is 3 cycles from draw_x/draw_y to outputs.
  - The pipeline is never stalled.
- Output masking: if the delayed inside=0, palette_index=0 and opaque=0. Otherwise palette_index=rom_q and opaque=(rom_q!=0).
- frame_num is not sampled into the pipeline. A change lands at most 2 pixels late, which is acceptable because ticks occur during blanking.
- Reset mid-operation: the pipeline flushes immediately to 0. The first valid output appears 3 cycles after Reset_n is released.

Decomposition:
- Shared package contra_sprite_pkg holds:
  - typedef coord_t = logic [9:0]
  - typedef pal_idx_t = logic [2:0]
  - constants ENEMY_W=24, ENEMY_H=32, ENEMY_FRAMES=3
  - constant KEY_INDEX=0
- One sub-module, sprite_anim_counter, covers the hold counter, the frame counter and the running clear. It is reusable by other sprites.

Test Plan:
- Reset while running mid-cycle -> all outputs 0 asynchronously; after release, palette_index stays 0 until the first inside pixel plus 3 cycles.
- Latch (100,50) on a tick, face_left=0, frame 0; draw (100,50) -> rom_addr=0 next cycle; rom_q=5 -> palette_index=5, opaque=1 three cycles after the draw.
- Same latch; draw (123,81) -> rom_addr=767. Draw (124,50) or (100,82) -> rom_addr=0, opaque=0.
- face_left=1, frame 0; draw (100,50) -> rom_addr=23. Draw (123,50) -> rom_addr=0.
- running=1, 18 frame_ticks -> frame_num sequence 0→1 at tick 6, →2 at tick 12, →0 at tick 18. With frame_num=2, draw (100,50) -> rom_addr=1536. running=0 coincident with a tick -> frame_num=0.
- Inside pixel with rom_q=0 -> palette_index=0, opaque=0. enemy_x=1010, draw_x=1020 -> inside, rom_addr col=10 (no wrap).
